// File: rtl/fwrisc_fetch.sv
// rtl/fwrisc_fetch.sv - instruction fetch stage with compressed/spanning assembly and a one-word buffer
//
// Ports:
//   clock, reset        sole clock; synchronous active-low reset
//   ibus_adr/ibus_req   word-aligned fetch request, held until ibus_ack
//   ibus_rdata/ibus_ack read data and single-cycle acknowledge
//   fetch_valid         instr/instr_c/pc valid for decode
//   decode_complete     decode consumed the instruction; next_pc/next_pc_seq sampled here
//   instr/instr_c/pc    assembled instruction, compressed flag and its address
//   next_pc/next_pc_seq address of the next instruction and whether it is sequential

module fwrisc_fetch #(
    parameter bit          ENABLE_COMPRESSED = 1'b1,
    parameter logic [31:0] RESET_VEC         = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ibus_adr,
    output logic        ibus_req,
    input  logic [31:0] ibus_rdata,
    input  logic        ibus_ack,
    output logic        fetch_valid,
    input  logic        decode_complete,
    output logic [31:0] instr,
    output logic        instr_c,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        next_pc_seq
);

    typedef enum logic [1:0] {
        S_FETCH0 = 2'd0,
        S_FETCH1 = 2'd1,
        S_VALID  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [29:0] buf_adr;
    logic [31:0] buf_data;
    logic        buf_vld;
    logic [15:0] span_half;

    logic        buf_hit;
    logic        word_rdy;
    logic [31:0] fetch_word;
    logic [15:0] half;
    logic        half_is_c;
    logic        spanning;
    logic [29:0] pc_word_nxt;

    // Buffer can only hit when compressed support is on; otherwise buf_vld stays 0.
    assign buf_hit     = ENABLE_COMPRESSED && buf_vld && (buf_adr == pc[31:2]);
    assign pc_word_nxt = pc[31:2] + 30'd1;

    // The request is a pure function of state so it rises in the first S_FETCH0
    // cycle and drops the cycle after ack. Gating with reset keeps the bus idle
    // while reset is held, which also abandons any transaction in flight.
    always_comb begin
        ibus_req = 1'b0;
        ibus_adr = 32'h0;
        if (reset) begin
            if (state == S_FETCH0 && !buf_hit) begin
                ibus_req = 1'b1;
                ibus_adr = {pc[31:2], 2'b00};
            end else if (state == S_FETCH1) begin
                ibus_req = 1'b1;
                ibus_adr = {pc_word_nxt, 2'b00};
            end
        end
    end

    assign fetch_valid = (state == S_VALID);

    // Word holding pc: from the buffer on a hit, otherwise from the bus on ack.
    // On a hit no request is outstanding, so any ack is ignored there.
    assign fetch_word = buf_hit ? buf_data : ibus_rdata;
    assign word_rdy   = (state == S_FETCH0) && (buf_hit || ibus_ack);
    assign half       = pc[1] ? fetch_word[31:16] : fetch_word[15:0];
    assign half_is_c  = ENABLE_COMPRESSED && (half[1:0] != 2'b11);
    // A 32-bit instruction starting in the upper halfword needs the next word too.
    assign spanning   = ENABLE_COMPRESSED && pc[1] && !half_is_c;

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH0: begin
                if (word_rdy) begin
                    state_nxt = spanning ? S_FETCH1 : S_VALID;
                end
            end
            S_FETCH1: begin
                if (ibus_ack) begin
                    state_nxt = S_VALID;
                end
            end
            S_VALID: begin
                if (decode_complete) begin
                    state_nxt = S_FETCH0;
                end
            end
            default: state_nxt = S_FETCH0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_FETCH0;
            pc        <= ENABLE_COMPRESSED ? RESET_VEC : {RESET_VEC[31:2], 2'b00};
            instr     <= 32'h0;
            instr_c   <= 1'b0;
            buf_adr   <= 30'h0;
            buf_data  <= 32'h0;
            buf_vld   <= 1'b0;
            span_half <= 16'h0;
        end else begin
            state <= state_nxt;
            case (state)
                S_FETCH0: begin
                    if (word_rdy) begin
                        if (!buf_hit) begin
                            buf_adr  <= pc[31:2];
                            buf_data <= ibus_rdata;
                            buf_vld  <= ENABLE_COMPRESSED;
                        end
                        if (half_is_c) begin
                            instr   <= {16'h0000, half};
                            instr_c <= 1'b1;
                        end else if (!spanning) begin
                            instr   <= fetch_word;
                            instr_c <= 1'b0;
                        end else begin
                            span_half <= half;
                        end
                    end
                end
                S_FETCH1: begin
                    if (ibus_ack) begin
                        instr    <= {ibus_rdata[15:0], span_half};
                        instr_c  <= 1'b0;
                        buf_adr  <= pc_word_nxt;
                        buf_data <= ibus_rdata;
                        buf_vld  <= ENABLE_COMPRESSED;
                    end
                end
                S_VALID: begin
                    if (decode_complete) begin
                        pc      <= ENABLE_COMPRESSED ? next_pc : {next_pc[31:2], 2'b00};
                        // A non-sequential target may have rewritten memory or
                        // changed context, so the buffer is dropped on any jump.
                        buf_vld <= buf_vld && next_pc_seq && ENABLE_COMPRESSED;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
